// File: rtl/mod3_share_arbiter.sv
// mod3_share_arbiter: round-robin arbiter in front of one shared bit-serial
// divisible-by-3 engine. A granted word is shifted MSB-first through a mod-3
// residue machine and the verdict is returned with the requester index.
// Optional build macro MOD3_ARB_REMAINDER_EN adds rsp_rem (final residue).
module mod3_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     rsp_div,
`ifdef MOD3_ARB_REMAINDER_EN
    output logic [1:0]               rsp_rem,
`endif
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   grant_idx;
    logic             grant_vld;
    logic             accept;
    logic [WIDTH-1:0] word_q;
    logic [IDW-1:0]   id_q;
    logic [1:0]       res_q;
    logic [1:0]       res_nxt;
    logic [CW-1:0]    cnt_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             rsp_div_q;
`ifdef MOD3_ARB_REMAINDER_EN
    logic [1:0]       rsp_rem_q;
`endif

    // One step of the residue machine: new residue of (2*r + b) mod 3.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        case ({r, b})
            3'b000:  mod3_step = 2'd0;
            3'b001:  mod3_step = 2'd1;
            3'b010:  mod3_step = 2'd2;
            3'b011:  mod3_step = 2'd0;
            3'b100:  mod3_step = 2'd1;
            3'b101:  mod3_step = 2'd2;
            default: mod3_step = 2'd0; // residue 3 is unreachable
        endcase
    endfunction

    assign res_nxt = mod3_step(res_q, word_q[WIDTH-1]);

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        // Walk from the farthest candidate back to rr_ptr so the nearest wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: one-hot ready to the granted requester while idle.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (state_q == IDLE && resetn && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
            accept               = 1'b1;
        end
        busy = (state_q != IDLE);
    end

    // Control registers: pointer, residue, bit count and registered response.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr_q    <= '0;
            res_q       <= 2'd0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_div_q   <= 1'b0;
`ifdef MOD3_ARB_REMAINDER_EN
            rsp_rem_q   <= 2'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        res_q    <= 2'd0;
                        cnt_q    <= CW'(WIDTH);
                        rr_ptr_q <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                SHIFT: begin
                    res_q <= res_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    // Last bit: capture the verdict from the final residue.
                    if (cnt_q == CW'(1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_div_q   <= (res_nxt == 2'd0);
`ifdef MOD3_ARB_REMAINDER_EN
                        rsp_rem_q   <= res_nxt;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Data registers: latch the granted word/ID, then shift MSB-first.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && accept) begin
            word_q <= req_data[grant_idx*WIDTH +: WIDTH];
            id_q   <= grant_idx;
        end else if (state_q == SHIFT) begin
            word_q <= word_q << 1;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_div   = rsp_div_q;
`ifdef MOD3_ARB_REMAINDER_EN
    assign rsp_rem   = rsp_rem_q;
`endif

endmodule

// File: tb/tb_mod3_share_arbiter.sv
// Testbench for mod3_share_arbiter: per-cycle comparison against a
// timeline model (round-robin pointer, WIDTH-cycle busy window, verdict via
// arithmetic mod 3) plus directed checks with hand-computed expectations.
// Build with MOD3_ARB_REMAINDER_EN to also check rsp_rem.
module tb_mod3_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk;
    logic                  resetn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_div;
`ifdef MOD3_ARB_REMAINDER_EN
    logic [1:0]            rsp_rem;
`endif
    logic                  busy;

    mod3_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_div   (rsp_div),
`ifdef MOD3_ARB_REMAINDER_EN
        .rsp_rem   (rsp_rem),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: phase 0 idle, 1 computing (m_left cycles to go), 2 responding.
    int m_phase = 0;
    int m_ptr   = 0;
    int m_left  = 0;
    int m_cur_id = 0;
    int m_cur_val = 0;
    int m_id_out = 0;
    int m_div_out = 0;
    int m_rem_out = 0;

    // Observation logs of DUT handshakes.
    int g_id[$];
    int g_cyc[$];
    int r_id[$];
    int r_div[$];
    int r_rem[$];
    int r_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: compare at the falling edge, advance the model, log handshakes.
    task automatic tick();
        int g;
        int gi;
        @(negedge clk);
        if (!resetn) begin
            m_phase = 0; m_ptr = 0; m_left = 0;
            m_id_out = 0; m_div_out = 0; m_rem_out = 0;
        end else begin
            g = (m_phase == 0) ? model_grant(req_valid, m_ptr) : -1;
            chk("req_ready", int'(req_ready), (g >= 0) ? (1 << g) : 0);
            chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
            chk("rsp_valid", int'(rsp_valid), (m_phase == 2) ? 1 : 0);
            chk("rsp_id", int'(rsp_id), m_id_out);
            chk("rsp_div", int'(rsp_div), m_div_out);
`ifdef MOD3_ARB_REMAINDER_EN
            chk("rsp_rem", int'(rsp_rem), m_rem_out);
`endif
            if ((req_valid & req_ready) != '0) begin
                gi = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
                g_id.push_back(gi);
                g_cyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(int'(rsp_id));
                r_div.push_back(int'(rsp_div));
`ifdef MOD3_ARB_REMAINDER_EN
                r_rem.push_back(int'(rsp_rem));
`else
                r_rem.push_back(0);
`endif
                r_cyc.push_back(cyc);
            end
            case (m_phase)
                0: if (g >= 0) begin
                    m_cur_id  = g;
                    m_cur_val = int'(req_data[g*WIDTH +: WIDTH]);
                    m_ptr     = (g + 1) % NREQ;
                    m_left    = WIDTH;
                    m_phase   = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase   = 2;
                        m_id_out  = m_cur_id;
                        m_rem_out = m_cur_val % 3;
                        m_div_out = (m_rem_out == 0) ? 1 : 0;
                    end
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int target, input int limit);
        int k = 0;
        while (g_id.size() < target && k < limit) begin
            tick();
            k++;
        end
        chk("grant_wait", (g_id.size() >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_resps(input int target, input int limit);
        int k = 0;
        while (r_id.size() < target && k < limit) begin
            tick();
            k++;
        end
        chk("resp_wait", (r_id.size() >= target) ? 1 : 0, 1);
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Present one word, drop valid once granted, wait for its verdict.
    task automatic send(input int id, input logic [WIDTH-1:0] d);
        req_data[id*WIDTH +: WIDTH] = d;
        req_valid[id] = 1'b1;
        wait_grants(g_id.size() + 1, 30);
        req_valid[id] = 1'b0;
        wait_resps(r_id.size() + 1, 40);
    endtask

    initial begin
        int base;
        int nr;
        int ng;
        int k;
        resetn    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset: ready stays low even with every requester valid.
        tick();
        req_valid = '1;
        tick();
        chk("reset_req_ready", int'(req_ready), 0);
        req_valid = '0;
        resetn = 1'b1;
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_rsp_div", int'(rsp_div), 0);
        chk("reset_busy", int'(busy), 0);

        // Test 1: 9 from requester 0, verdict 9 cycles after the accept.
        send(0, 8'd9);
        chk("t1_id", r_id[$], 0);
        chk("t1_div", r_div[$], 1);
        chk("t1_latency", r_cyc[$] - g_cyc[$], WIDTH + 1);
        chk("t1_idle_after", int'(busy), 0);

        // Test 2: requester 2 sends 10, 0, 0xFF.
        send(2, 8'd10);
        chk("t2a_id", r_id[$], 2);
        chk("t2a_div", r_div[$], 0);
        send(2, 8'd0);
        chk("t2b_id", r_id[$], 2);
        chk("t2b_div", r_div[$], 1);
        send(2, 8'hFF);
        chk("t2c_id", r_id[$], 2);
        chk("t2c_div", r_div[$], 1);

        // Test 3: all valid -> 0,1,2,3,0 every 10 cycles; then drop 1 -> 2,3,0,2.
        reset_dut();
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(3 * i + 4);
        base = g_id.size();
        req_valid = '1;
        wait_grants(base + 5, 100);
        req_valid[1] = 1'b0;
        wait_grants(base + 9, 100);
        req_valid = '0;
        k = 0;
        while (busy && k < 40) begin tick(); k++; end
        chk("t3_drain", int'(busy), 0);
        if (g_id.size() >= base + 9) begin
            chk("t3_g0", g_id[base + 0], 0);
            chk("t3_g1", g_id[base + 1], 1);
            chk("t3_g2", g_id[base + 2], 2);
            chk("t3_g3", g_id[base + 3], 3);
            chk("t3_g4", g_id[base + 4], 0);
            for (int i = 1; i < 5; i++)
                chk("t3_spacing", g_cyc[base + i] - g_cyc[base + i - 1], WIDTH + 2);
            chk("t3_g5", g_id[base + 5], 2);
            chk("t3_g6", g_id[base + 6], 3);
            chk("t3_g7", g_id[base + 7], 0);
            chk("t3_g8", g_id[base + 8], 2);
        end

        // Test 4: consumer stalls 5 cycles in RESP; next grant right after accept.
        rsp_ready = 1'b0;
        req_data[1*WIDTH +: WIDTH] = 8'd6;
        req_data[2*WIDTH +: WIDTH] = 8'd5;
        req_valid[1] = 1'b1;
        wait_grants(g_id.size() + 1, 30);
        chk("t4_first_id", g_id[$], 1);
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b1;
        k = 0;
        while (!rsp_valid && k < 40) begin tick(); k++; end
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", int'(rsp_valid), 1);
            chk("t4_hold_id", int'(rsp_id), 1);
            chk("t4_hold_div", int'(rsp_div), 1);
            chk("t4_hold_ready", int'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        nr = r_id.size();
        ng = g_id.size();
        tick();
        tick();
        chk("t4_resp_taken", r_id.size(), nr + 1);
        chk("t4_next_grant", g_id.size(), ng + 1);
        if (r_id.size() == nr + 1 && g_id.size() == ng + 1) begin
            chk("t4_gap", g_cyc[$] - r_cyc[$], 1);
            chk("t4_next_id", g_id[$], 2);
        end
        req_valid[2] = 1'b0;
        wait_resps(nr + 2, 40);
        chk("t4_second_div", r_div[$], 0);

        // Test 5: reset mid-SHIFT aborts requester 3; requester 0 wins afterwards.
        reset_dut();
        req_data[3*WIDTH +: WIDTH] = 8'd21;
        req_valid[3] = 1'b1;
        wait_grants(g_id.size() + 1, 30);
        chk("t5_first_id", g_id[$], 3);
        req_valid[3] = 1'b0;
        tick();
        tick();
        nr = r_id.size();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req_data[0] = 1'b0;
        req_data[0*WIDTH +: WIDTH] = 8'd4;
        req_valid = 4'b1001;
        wait_grants(g_id.size() + 1, 30);
        chk("t5_grant_after_reset", g_id[$], 0);
        req_valid = '0;
        wait_resps(nr + 1, 40);
        repeat (5) tick();
        chk("t5_resp_count", r_id.size(), nr + 1);
        chk("t5_resp_id", r_id[$], 0);
        chk("t5_resp_div", r_div[$], 0);

        // Test 6: 11, 7, 12 -> residues 2, 1, 0.
        reset_dut();
        send(0, 8'd11);
        chk("t6a_div", r_div[$], 0);
`ifdef MOD3_ARB_REMAINDER_EN
        chk("t6a_rem", r_rem[$], 2);
`endif
        send(0, 8'd7);
        chk("t6b_div", r_div[$], 0);
`ifdef MOD3_ARB_REMAINDER_EN
        chk("t6b_rem", r_rem[$], 1);
`endif
        send(0, 8'd12);
        chk("t6c_div", r_div[$], 1);
`ifdef MOD3_ARB_REMAINDER_EN
        chk("t6c_rem", r_rem[$], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod3_share_arbiter.md
Name: mod3_share_arbiter

Overview:
- Shares one bit-serial divisible-by-3 residue engine between NREQ requesters.
- Each requester presents a WIDTH-bit word over a valid/ready handshake.
- A round-robin arbiter picks one word. The controller shifts it MSB-first through a mod-3 residue FSM, then returns a divisibility verdict tagged with the requester ID.
- Sits between several producer blocks and the shared serial checker datapath.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, bits per request word; legal range 1..32.
- IDW (localparam), $clog2(NREQ), width of rsp_id.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- req_valid  in  NREQ  bit i: requester i has a word pending.
- req_ready  out  NREQ  bit i: word from requester i accepted this cycle.
- req_data  in  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH].
- rsp_valid  out  1  verdict available.
- rsp_ready  in  1  consumer accepts verdict.
- rsp_id  out  IDW  requester index of the verdict.
- rsp_div  out  1  1 = word divisible by 3.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: resetn synchronous, active-low; clock clk, rising edge.
  - state=IDLE, rr_ptr=0, residue=0, bit count=0.
  - rsp_valid=0, rsp_id=0, rsp_div=0, busy=0, req_ready=0.
- States: IDLE -> SHIFT -> RESP -> IDLE.
- IDLE:
  - Grant is combinational: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready = one-hot of the grant; all zero if no valid or state != IDLE.
  - On handshake: latch req_data slice and ID, residue<=0, cnt<=WIDTH, rr_ptr<=(grant+1) mod NREQ, go to SHIFT.
- SHIFT:
  - Each cycle: residue <= (2*residue + msb) mod 3, word <<= 1, cnt <= cnt-1.
  - Residue transitions: r0 -0-> r0, r0 -1-> r1, r1 -0-> r2, r1 -1-> r0, r2 -0-> r1, r2 -1-> r2.
  - When cnt reaches 1, go to RESP after that shift.
  - SHIFT lasts exactly WIDTH cycles.
- RESP:
  - rsp_valid=1, rsp_div=(residue==0), rsp_id=latched ID.
  - All response outputs are registered and held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready, go to IDLE.
- Timing:
  - Accept in cycle 0; SHIFT in cycles 1..WIDTH; rsp_valid first high in cycle WIDTH+1.
  - Minimum request spacing is WIDTH+2 cycles, with no same-cycle response-to-grant overlap.
- Outside RESP, rsp_valid=0; rsp_id and rsp_div keep their last values.
- Protocol: a requester must hold req_valid and data until it sees req_ready. Dropping req_valid before grant is legal and is ignored.
- Word 0 gives rsp_div=1; the all-ones word is divisible iff WIDTH is even.
- rsp_ready is ignored outside RESP.
- req_valid changes during SHIFT or RESP have no effect; the next arbitration uses the levels present in IDLE.
- resetn low mid-SHIFT or mid-RESP aborts the operation with no response. rr_ptr returns to 0, so requester 0 has priority next.
- Bit count width is $clog2(WIDTH+1); residue is 2 bits, value 3 is never reached.

Optional Feature:
- Macro MOD3_ARB_REMAINDER_EN.
- When defined:
  - Adds output rsp_rem [1:0] = final residue (0..2), valid with rsp_valid.
  - rsp_rem resets to 0 and holds like rsp_div.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
1. Only req_valid[0]=1, data 8'd9, rsp_ready=1 -> req_ready[0] in cycle 0; rsp_valid in cycle 9 with rsp_id=0, rsp_div=1; IDLE in cycle 10.
2. Requester 2 sends 8'd10, then 8'd0, then 8'hFF -> rsp_div = 0, 1, 1 respectively, each with rsp_id=2.
3. All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0 with accepts every 10 cycles. Then drop valid[1]: order continues 2,3,0,2.
4. rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_id and rsp_div stable; req_ready=0 throughout; accept on cycle 6, next grant the following cycle.
5. resetn low in SHIFT cycle 3 after granting requester 3 -> no rsp_valid ever for that word. After release, valid[0] and valid[3] both high -> requester 0 granted.
6. With MOD3_ARB_REMAINDER_EN: 8'd11 -> rsp_div=0, rsp_rem=2; 8'd7 -> rsp_rem=1; 8'd12 -> rsp_rem=0.
